ex_mem_flag_stage: RTL and testbench

- EX/MEM boundary stage directly downstream of the 16-bit saturating ALU.
- Latches the ALU result and writeback control into the MEM stage.
- Owns the architectural Z/V/N flag register and applies the per-opcode flag-update rules; the ALU produces ov/zr/ne unconditionally.
- Applies the addz write-enable gating and resolves conditional branches against the flag register, producing a registered taken/target to fetch.

---
 rtl/ex_mem_flag_stage.sv | 158 +++++++++++++++
 tb/tb_ex_mem_flag_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline boundary: latches the ALU result and writeback control,
// owns the Z/V/N flag register, gates addz and resolves conditional branches.
module ex_mem_flag_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_vld,
  input  logic [2:0]    ex_alu_ctrl,
  input  logic          ex_is_alu,
  input  logic          ex_is_addz,
  input  logic          ex_is_br,
  input  logic [2:0]    ex_ccc,
  input  logic [DW-1:0] ex_br_tgt,
  input  logic          ex_rf_we,
  input  logic [RW-1:0] ex_rf_dst,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_ov,
  input  logic          alu_zr,
  input  logic          alu_ne,
  output logic          mem_vld,
  output logic [DW-1:0] mem_result,
  output logic          mem_rf_we,
  output logic [RW-1:0] mem_rf_dst,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          br_taken,
  output logic [DW-1:0] br_tgt
);

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_LHB = 3'b001;
  localparam logic [2:0] CTRL_SUB = 3'b010;

  logic          mem_vld_r, mem_rf_we_r, br_taken_r;
  logic [DW-1:0] mem_result_r, br_tgt_r;
  logic [RW-1:0] mem_rf_dst_r;
  logic          flag_z_r, flag_v_r, flag_n_r;

  logic          mem_vld_s, mem_rf_we_s, br_taken_s;
  logic [DW-1:0] mem_result_s, br_tgt_s;
  logic [RW-1:0] mem_rf_dst_s;
  logic          flag_z_s, flag_v_s, flag_n_s;
  logic          bubble_s, exec_s, cond_s;

  // Branch condition evaluated against the flags as they stood before this edge.
  function automatic logic cond_eval(input logic [2:0] ccc, input logic z,
                                     input logic v, input logic n);
    logic r;
    case (ccc)
      3'b000:  r = ~z;
      3'b001:  r = z;
      3'b010:  r = ~z & ~n;
      3'b011:  r = n;
      3'b100:  r = z | ~n;
      3'b101:  r = n | z;
      3'b110:  r = v;
      3'b111:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Classify this cycle and resolve addz gating and the branch condition.
  always_comb begin
    bubble_s = flush | (~stall & ~ex_vld);
    exec_s   = ~ex_is_addz | flag_z_r;
    cond_s   = cond_eval(ex_ccc, flag_z_r, flag_v_r, flag_n_r);
  end

  // Next-state for the MEM registers and flag register; stall falls through to hold.
  always_comb begin
    mem_vld_s    = mem_vld_r;
    mem_rf_we_s  = mem_rf_we_r;
    mem_result_s = mem_result_r;
    mem_rf_dst_s = mem_rf_dst_r;
    br_taken_s   = br_taken_r;
    br_tgt_s     = br_tgt_r;
    flag_z_s     = flag_z_r;
    flag_v_s     = flag_v_r;
    flag_n_s     = flag_n_r;
    if (bubble_s) begin
      mem_vld_s    = 1'b0;
      mem_rf_we_s  = 1'b0;
      mem_result_s = {DW{1'b0}};
      mem_rf_dst_s = {RW{1'b0}};
      br_taken_s   = 1'b0;
      br_tgt_s     = {DW{1'b0}};
    end else if (stall) begin
      mem_vld_s = mem_vld_r;
    end else begin
      mem_vld_s    = 1'b1;
      mem_rf_we_s  = ex_rf_we & exec_s;
      mem_result_s = alu_result;
      mem_rf_dst_s = ex_rf_dst;
      br_taken_s   = ex_is_br & cond_s;
      br_tgt_s     = ex_br_tgt;
      // A suppressed addz and any non-ALU instruction leave the flags alone.
      if (ex_is_alu && exec_s) begin
        case (ex_alu_ctrl)
          CTRL_ADD, CTRL_SUB: begin
            flag_z_s = alu_zr;
            flag_v_s = alu_ov;
            flag_n_s = alu_ne;
          end
          CTRL_LHB: begin
            flag_z_s = flag_z_r;
          end
          default: begin
            flag_z_s = alu_zr;
          end
        endcase
      end else begin
        flag_z_s = flag_z_r;
      end
    end
  end

  // State registers with synchronous active-low reset overriding stall and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_vld_r    <= 1'b0;
      mem_rf_we_r  <= 1'b0;
      mem_result_r <= {DW{1'b0}};
      mem_rf_dst_r <= {RW{1'b0}};
      br_taken_r   <= 1'b0;
      br_tgt_r     <= {DW{1'b0}};
      flag_z_r     <= 1'b0;
      flag_v_r     <= 1'b0;
      flag_n_r     <= 1'b0;
    end else begin
      mem_vld_r    <= mem_vld_s;
      mem_rf_we_r  <= mem_rf_we_s;
      mem_result_r <= mem_result_s;
      mem_rf_dst_r <= mem_rf_dst_s;
      br_taken_r   <= br_taken_s;
      br_tgt_r     <= br_tgt_s;
      flag_z_r     <= flag_z_s;
      flag_v_r     <= flag_v_s;
      flag_n_r     <= flag_n_s;
    end
  end

  assign mem_vld    = mem_vld_r;
  assign mem_rf_we  = mem_rf_we_r;
  assign mem_result = mem_result_r;
  assign mem_rf_dst = mem_rf_dst_r;
  assign br_taken   = br_taken_r;
  assign br_tgt     = br_tgt_r;
  assign flag_z     = flag_z_r;
  assign flag_v     = flag_v_r;
  assign flag_n     = flag_n_r;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: driver pushes hand-computed expectations,
// a monitor pops one per clock edge and compares against the DUT outputs.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, ex_vld;
  logic [2:0]  ex_alu_ctrl, ex_ccc;
  logic        ex_is_alu, ex_is_addz, ex_is_br, ex_rf_we;
  logic [15:0] ex_br_tgt, alu_result;
  logic [3:0]  ex_rf_dst;
  logic        alu_ov, alu_zr, alu_ne;
  logic        mem_vld, mem_rf_we, flag_z, flag_v, flag_n, br_taken;
  logic [15:0] mem_result, br_tgt;
  logic [3:0]  mem_rf_dst;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          id;
    logic        vld, we;
    logic [15:0] res;
    logic [3:0]  dst;
    logic        z, v, n, bt;
    logic [15:0] tgt;
  } exp_t;

  exp_t sb[$];

  ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_vld(ex_vld),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_is_alu(ex_is_alu), .ex_is_addz(ex_is_addz),
    .ex_is_br(ex_is_br), .ex_ccc(ex_ccc), .ex_br_tgt(ex_br_tgt),
    .ex_rf_we(ex_rf_we), .ex_rf_dst(ex_rf_dst), .alu_result(alu_result),
    .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_ne(alu_ne),
    .mem_vld(mem_vld), .mem_result(mem_result), .mem_rf_we(mem_rf_we),
    .mem_rf_dst(mem_rf_dst), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .br_taken(br_taken), .br_tgt(br_tgt)
  );

  always #5 clk = ~clk;

  task automatic chk(input int id, input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.id, "mem_vld",   {15'd0, mem_vld},   {15'd0, e.vld});
        chk(e.id, "mem_rf_we", {15'd0, mem_rf_we}, {15'd0, e.we});
        chk(e.id, "flag_z",    {15'd0, flag_z},    {15'd0, e.z});
        chk(e.id, "flag_v",    {15'd0, flag_v},    {15'd0, e.v});
        chk(e.id, "flag_n",    {15'd0, flag_n},    {15'd0, e.n});
        chk(e.id, "br_taken",  {15'd0, br_taken},  {15'd0, e.bt});
        if (e.vld) begin
          chk(e.id, "mem_result", mem_result, e.res);
          chk(e.id, "mem_rf_dst", {12'd0, mem_rf_dst}, {12'd0, e.dst});
        end
        if (e.bt) chk(e.id, "br_tgt", br_tgt, e.tgt);
      end
    end
  end

  // Apply one cycle of stimulus at the falling edge and queue its expected outcome.
  task automatic issue(input int id, input logic rst, input logic stl, input logic fl,
                       input logic vld, input logic [2:0] ctrl, input logic alu,
                       input logic addz, input logic br, input logic [2:0] ccc,
                       input logic [15:0] tgt, input logic we, input logic [3:0] dst,
                       input logic [15:0] res, input logic ov, input logic zr,
                       input logic ne,
                       input logic e_vld, input logic e_we, input logic [15:0] e_res,
                       input logic [3:0] e_dst, input logic e_z, input logic e_v,
                       input logic e_n, input logic e_bt, input logic [15:0] e_tgt);
    exp_t e;
    @(negedge clk);
    rst_n = ~rst; stall = stl; flush = fl; ex_vld = vld;
    ex_alu_ctrl = ctrl; ex_is_alu = alu; ex_is_addz = addz; ex_is_br = br;
    ex_ccc = ccc; ex_br_tgt = tgt; ex_rf_we = we; ex_rf_dst = dst;
    alu_result = res; alu_ov = ov; alu_zr = zr; alu_ne = ne;
    e.id = id; e.vld = e_vld; e.we = e_we; e.res = e_res; e.dst = e_dst;
    e.z = e_z; e.v = e_v; e.n = e_n; e.bt = e_bt; e.tgt = e_tgt;
    sb.push_back(e);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0; ex_vld = 1'b1;
    ex_alu_ctrl = 3'd0; ex_is_alu = 1'b1; ex_is_addz = 1'b0; ex_is_br = 1'b0;
    ex_ccc = 3'd0; ex_br_tgt = 16'h0; ex_rf_we = 1'b1; ex_rf_dst = 4'd0;
    alu_result = 16'h0; alu_ov = 1'b0; alu_zr = 1'b0; alu_ne = 1'b0;

    //     id rst stl fl vld ctrl alu addz br ccc tgt     we dst res      ov zr ne |vld we res      dst  z v n bt tgt
    // reset with stall and a valid ALU op presented
    issue(0, 1'b1,1'b1,1'b0,1'b1,3'b010,1'b1,1'b0,1'b1,3'b111,16'h1234,1'b1,4'd9,16'hABCD,1'b1,1'b1,1'b1, 1'b0,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    issue(1, 1'b1,1'b1,1'b0,1'b1,3'b010,1'b1,1'b0,1'b1,3'b111,16'h1234,1'b1,4'd9,16'hABCD,1'b1,1'b1,1'b1, 1'b0,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    // sub overflow, and sets Z only, lhb leaves flags
    issue(2, 1'b0,1'b0,1'b0,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd3,16'h7FFF,1'b1,1'b0,1'b0, 1'b1,1'b1,16'h7FFF,4'd3, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    issue(3, 1'b0,1'b0,1'b0,1'b1,3'b011,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd4,16'h0000,1'b0,1'b1,1'b1, 1'b1,1'b1,16'h0000,4'd4, 1'b1,1'b1,1'b0,1'b0,16'h0000);
    issue(4, 1'b0,1'b0,1'b0,1'b1,3'b001,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd5,16'h1200,1'b1,1'b0,1'b1, 1'b1,1'b1,16'h1200,4'd5, 1'b1,1'b1,1'b0,1'b0,16'h0000);
    // nor clears Z, then addz is suppressed
    issue(5, 1'b0,1'b0,1'b0,1'b1,3'b100,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd6,16'h00FF,1'b1,1'b0,1'b1, 1'b1,1'b1,16'h00FF,4'd6, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    issue(6, 1'b0,1'b0,1'b0,1'b1,3'b000,1'b1,1'b1,1'b0,3'b000,16'h0000,1'b1,4'd7,16'h1111,1'b1,1'b1,1'b1, 1'b1,1'b0,16'h1111,4'd7, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    // add sets Z, addz then executes
    issue(7, 1'b0,1'b0,1'b0,1'b1,3'b000,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd1,16'h0000,1'b0,1'b1,1'b0, 1'b1,1'b1,16'h0000,4'd1, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    issue(8, 1'b0,1'b0,1'b0,1'b1,3'b000,1'b1,1'b1,1'b0,3'b000,16'h0000,1'b1,4'd2,16'h8000,1'b0,1'b0,1'b1, 1'b1,1'b1,16'h8000,4'd2, 1'b0,1'b0,1'b1,1'b0,16'h0000);
    // clear all flags, then gt taken, lt not taken
    issue(9, 1'b0,1'b0,1'b0,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd1,16'h0001,1'b0,1'b0,1'b0, 1'b1,1'b1,16'h0001,4'd1, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    issue(10,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,1'b1,3'b010,16'h0040,1'b0,4'd0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b1,16'h0040);
    issue(11,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,1'b1,3'b011,16'h0050,1'b0,4'd0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    // set Z,V,N; uncond taken
    issue(12,1'b0,1'b0,1'b0,1'b1,3'b000,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd8,16'h0000,1'b1,1'b1,1'b1, 1'b1,1'b1,16'h0000,4'd8, 1'b1,1'b1,1'b1,1'b0,16'h0000);
    issue(13,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,1'b1,3'b111,16'h0123,1'b0,4'd0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,16'h0000,4'd0, 1'b1,1'b1,1'b1,1'b1,16'h0123);
    // three stalled cycles with a flag-clearing sub presented: everything frozen
    for (int k = 0; k < 3; k++)
      issue(14+k,1'b0,1'b1,1'b0,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd3,16'h0005,1'b0,1'b0,1'b0, 1'b1,1'b0,16'h0000,4'd0, 1'b1,1'b1,1'b1,1'b1,16'h0123);
    // flush with stall: bubble, flags held
    issue(17,1'b0,1'b1,1'b1,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd3,16'h0005,1'b0,1'b0,1'b0, 1'b0,1'b0,16'h0000,4'd0, 1'b1,1'b1,1'b1,1'b0,16'h0000);
    // ex_vld=0 with an uncond branch presented: bubble
    issue(18,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,3'b111,16'h0777,1'b1,4'd3,16'h0005,1'b0,1'b0,1'b0, 1'b0,1'b0,16'h0000,4'd0, 1'b1,1'b1,1'b1,1'b0,16'h0000);
    // back-to-back: sub clears, sub sets Z, eq branch taken next cycle
    issue(19,1'b0,1'b0,1'b0,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd2,16'h0005,1'b0,1'b0,1'b0, 1'b1,1'b1,16'h0005,4'd2, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    issue(20,1'b0,1'b0,1'b0,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd2,16'h0000,1'b0,1'b1,1'b0, 1'b1,1'b1,16'h0000,4'd2, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    issue(21,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,1'b1,3'b001,16'h0200,1'b0,4'd0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,16'h0000,4'd0, 1'b1,1'b0,1'b0,1'b1,16'h0200);
    // clear Z, flush a Z-setting sub, eq branch (with ALU flags asserted) falls through
    issue(22,1'b0,1'b0,1'b0,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd4,16'h0003,1'b0,1'b0,1'b0, 1'b1,1'b1,16'h0003,4'd4, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    issue(23,1'b0,1'b0,1'b1,1'b1,3'b010,1'b1,1'b0,1'b0,3'b000,16'h0000,1'b1,4'd4,16'h0000,1'b1,1'b1,1'b1, 1'b0,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    issue(24,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,1'b1,3'b001,16'h0300,1'b0,4'd0,16'h0000,1'b1,1'b1,1'b1, 1'b1,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b0,16'h0000);
    // gte taken with Z=0,N=0, then a bubble clears the pulse
    issue(25,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,1'b1,3'b100,16'h0400,1'b0,4'd0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b1,16'h0400);
    issue(26,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,3'b000,16'h0000,1'b0,4'd0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,16'h0000,4'd0, 1'b0,1'b0,1'b0,1'b0,16'h0000);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
